// File: rtl/hamming_pkg.sv
// Shared types and width helpers for the Hamming min/max engine.
package hamming_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PAIR,
    DONE
  } state_t;

  // Bits needed to hold a distance in 0..w.
  function automatic int dist_width(input int w);
    return $clog2(w + 1);
  endfunction

  // Bits needed to hold an operand index in 0..n-1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hamming_popcount.sv
// Combinational Hamming distance between two W-bit operands: popcount(a ^ b).
module hamming_popcount
  import hamming_pkg::*;
#(
  parameter  int W   = 16,
  localparam int DIW = dist_width(W)
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [DIW-1:0] d
);

  logic [W-1:0] diff;

  assign diff = a ^ b;

  // Count the set bits of the XOR.
  always_comb begin
    // NOTE: blocking assignments here on purpose -- each loop step must see the
    // running sum left by the previous step within the same evaluation.
    d = '0;
    for (int i = 0; i < W; i++) begin
      d = d + DIW'(diff[i]);
    end
  end

endmodule

// File: rtl/hamming_minmax_engine.sv
// Loads N W-bit operands from byte memory, then scans all unordered pairs once
// to report the minimum and maximum Hamming distance and the first pair hitting each.
module hamming_minmax_engine
  import hamming_pkg::*;
#(
  parameter  int W   = 16,
  parameter  int N   = 32,
  parameter  int DW  = 8,
  parameter  int AW  = 8,
  localparam int BPW = W / DW,
  localparam int DIW = dist_width(W),
  localparam int IW  = idx_width(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [AW-1:0]  base_addr,
  output logic           mem_rd_en,
  output logic [AW-1:0]  mem_addr,
  input  logic [DW-1:0]  mem_rdata,
  output logic           busy,
  output logic           done,
  output logic [DIW-1:0] min_dist,
  output logic [DIW-1:0] max_dist,
  output logic [IW-1:0]  min_idx_a,
  output logic [IW-1:0]  min_idx_b,
  output logic [IW-1:0]  max_idx_a,
  output logic [IW-1:0]  max_idx_b
);

  localparam int NB = N * BPW;                      // bytes to fetch
  localparam int CW = $clog2(NB + 1);               // LOAD counter spans 0..NB
  localparam int BW = (BPW > 1) ? $clog2(BPW) : 1;  // byte-within-operand counter

  state_t            state;
  state_t            next_state;
  logic [AW-1:0]     base;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     cap_byte;
  logic [IW-1:0]     cap_word;
  logic [IW-1:0]     pj;
  logic [IW-1:0]     pk;
  logic [W-1:0]      ops [N];
  logic [W+DW-1:0]   shifted;
  logic [DIW-1:0]    d;
  logic              accept;
  logic              capture;
  logic              last_pair;

  // A start is honoured only when no run is in flight.
  assign accept    = ((state == IDLE) || (state == DONE)) && start;
  // Cycle 0 of LOAD only issues; every later LOAD cycle returns the byte issued before it.
  assign capture   = (state == LOAD) && (cnt != '0);
  assign last_pair = (pj == IW'(N - 2)) && (pk == IW'(N - 1));
  // First byte fetched ends up most significant once BPW bytes are shifted in.
  assign shifted   = {ops[cap_word], mem_rdata};

  hamming_popcount #(.W(W)) u_pop (
    .a (ops[pj]),
    .b (ops[pk]),
    .d (d)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic and the outputs decoded from state.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    mem_rd_en  = 1'b0;
    mem_addr   = '0;
    unique case (state)
      IDLE: begin
        if (start) next_state = LOAD;
      end
      LOAD: begin
        busy = 1'b1;
        if (cnt < CW'(NB)) begin
          mem_rd_en = 1'b1;
          mem_addr  = base + AW'(cnt);  // wraps modulo 2^AW
        end else begin
          next_state = PAIR;
        end
      end
      PAIR: begin
        busy = 1'b1;
        if (last_pair) next_state = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) next_state = LOAD;
      end
      default: next_state = IDLE;
    endcase
  end

  // Run setup, fetch/capture counters, pair walk and strict min/max tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base      <= '0;
      cnt       <= '0;
      cap_byte  <= '0;
      cap_word  <= '0;
      pj        <= '0;
      pk        <= '0;
      min_dist  <= DIW'(W);
      max_dist  <= '0;
      min_idx_a <= '0;
      min_idx_b <= '0;
      max_idx_a <= '0;
      max_idx_b <= '0;
    end else if (accept) begin
      base      <= base_addr;
      cnt       <= '0;
      cap_byte  <= '0;
      cap_word  <= '0;
      pj        <= '0;
      pk        <= IW'(1);
      min_dist  <= DIW'(W);
      max_dist  <= '0;
      min_idx_a <= '0;
      min_idx_b <= '0;
      max_idx_a <= '0;
      max_idx_b <= '0;
    end else if (state == LOAD) begin
      cnt <= cnt + CW'(1);
      if (capture) begin
        if (cap_byte == BW'(BPW - 1)) begin
          cap_byte <= '0;
          cap_word <= cap_word + IW'(1);
        end else begin
          cap_byte <= cap_byte + BW'(1);
        end
      end
    end else if (state == PAIR) begin
      // Strict compares keep the lexicographically first pair on ties.
      if (d < min_dist) begin
        min_dist  <= d;
        min_idx_a <= pj;
        min_idx_b <= pk;
      end
      if (d > max_dist) begin
        max_dist  <= d;
        max_idx_a <= pj;
        max_idx_b <= pk;
      end
      if (pk == IW'(N - 1)) begin
        pj <= pj + IW'(1);
        pk <= pj + IW'(2);
      end else begin
        pk <= pk + IW'(1);
      end
    end
  end

  // Operand buffer: one byte shifted into the current operand per capture cycle.
  always_ff @(posedge clk) begin
    // NOTE: the operand array is deliberately left out of reset; every entry is
    // rewritten in LOAD before PAIR reads it, so a reset would only cost logic.
    if (capture) ops[cap_word] <= shifted[W-1:0];
  end

endmodule

// File: tb/tb_hamming_minmax_engine.sv
// Directed bench: default instance (W=16, N=32) plus a W=32, N=2 instance
// exercising address wrap, complementary and identical operands.
module tb_hamming_minmax_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] base_addr = '0;

  // Default instance.
  logic       d_start = 1'b0;
  logic       d_rd_en, d_busy, d_done;
  logic [7:0] d_addr, d_rdata;
  logic [4:0] d_min, d_max;
  logic [4:0] d_mina, d_minb, d_maxa, d_maxb;
  logic [7:0] mem_d [256];

  // Small instance: W=32, N=2.
  logic       s_start = 1'b0;
  logic       s_rd_en, s_busy, s_done;
  logic [7:0] s_addr, s_rdata;
  logic [5:0] s_min, s_max;
  logic       s_mina, s_minb, s_maxa, s_maxb;
  logic [7:0] mem_s [256];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hamming_minmax_engine dut (
    .clk(clk), .reset(reset), .start(d_start), .base_addr(base_addr),
    .mem_rd_en(d_rd_en), .mem_addr(d_addr), .mem_rdata(d_rdata),
    .busy(d_busy), .done(d_done), .min_dist(d_min), .max_dist(d_max),
    .min_idx_a(d_mina), .min_idx_b(d_minb), .max_idx_a(d_maxa), .max_idx_b(d_maxb)
  );

  hamming_minmax_engine #(.W(32), .N(2)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .base_addr(base_addr),
    .mem_rd_en(s_rd_en), .mem_addr(s_addr), .mem_rdata(s_rdata),
    .busy(s_busy), .done(s_done), .min_dist(s_min), .max_dist(s_max),
    .min_idx_a(s_mina), .min_idx_b(s_minb), .max_idx_a(s_maxa), .max_idx_b(s_maxb)
  );

  // Synchronous-read memories; junk is returned when no read is strobed.
  always @(posedge clk) d_rdata <= d_rd_en ? mem_d[d_addr] : 8'($urandom);
  always @(posedge clk) s_rdata <= s_rd_en ? mem_s[s_addr] : 8'($urandom);

  // View of whichever instance the current test targets.
  logic       sel = 1'b0;
  logic       v_busy, v_done, v_rd;
  logic [7:0] v_addr, v_min, v_max, v_mina, v_minb, v_maxa, v_maxb;
  assign v_busy = sel ? s_busy  : d_busy;
  assign v_done = sel ? s_done  : d_done;
  assign v_rd   = sel ? s_rd_en : d_rd_en;
  assign v_addr = sel ? s_addr  : d_addr;
  assign v_min  = sel ? 8'(s_min)  : 8'(d_min);
  assign v_max  = sel ? 8'(s_max)  : 8'(d_max);
  assign v_mina = sel ? 8'(s_mina) : 8'(d_mina);
  assign v_minb = sel ? 8'(s_minb) : 8'(d_minb);
  assign v_maxa = sel ? 8'(s_maxa) : 8'(d_maxa);
  assign v_maxb = sel ? 8'(s_maxb) : 8'(d_maxb);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_results(input string tag, input int emin, input int emina, input int eminb,
                               input int emax, input int emaxa, input int emaxb);
    check({tag, ":min_dist"}, v_min, 64'(emin));
    check({tag, ":min_idx_a"}, v_mina, 64'(emina));
    check({tag, ":min_idx_b"}, v_minb, 64'(eminb));
    check({tag, ":max_dist"}, v_max, 64'(emax));
    check({tag, ":max_idx_a"}, v_maxa, 64'(emaxa));
    check({tag, ":max_idx_b"}, v_maxb, 64'(emaxb));
  endtask

  // One complete run: accept, fetch, pair scan, latency and results.
  task automatic run(input bit s, input logic [7:0] base, input int nb, input int lat,
                     input bit poke, input int w, input string tag,
                     input int emin, input int emina, input int eminb,
                     input int emax, input int emaxa, input int emaxb);
    int         n;
    logic [7:0] a2;
    sel = s;
    @(negedge clk);
    base_addr = base;
    if (s) s_start = 1'b1; else d_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    d_start = 1'b0;
    check({tag, ":busy@accept"}, v_busy, 1);
    check({tag, ":done@accept"}, v_done, 0);
    check({tag, ":min@accept"}, v_min, 64'(w));
    check({tag, ":max@accept"}, v_max, 0);
    check({tag, ":rd_en@accept"}, v_rd, 1);
    check({tag, ":addr@accept"}, v_addr, base);
    a2 = base + 8'd2;
    n = 0;
    while (!v_done && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (n == 2)  check({tag, ":addr+2"}, v_addr, a2);
      if (n == nb) check({tag, ":rd_en_off"}, v_rd, 0);
      // Starts (with a different base) while busy must be ignored.
      if (poke && (n == 20 || n == 300)) begin
        d_start   = 1'b1;
        base_addr = 8'h00;
      end else begin
        d_start = 1'b0;
      end
    end
    d_start = 1'b0;
    check({tag, ":latency"}, n, lat);
    check({tag, ":busy@done"}, v_busy, 0);
    check_results(tag, emin, emina, eminb, emax, emaxa, emaxb);
  endtask

  initial begin
    // 0x00..0x3F: operand 5 = 0xFFFF, rest 0. 0x40..0x7F: 1,2,4,8 then 0x00FF. 0x80..: zero.
    for (int i = 0; i < 256; i++) begin
      mem_d[i] = 8'h00;
      mem_s[i] = 8'h00;
    end
    mem_d[8'h0A] = 8'hFF;
    mem_d[8'h0B] = 8'hFF;
    mem_d[8'h41] = 8'h01;
    mem_d[8'h43] = 8'h02;
    mem_d[8'h45] = 8'h04;
    mem_d[8'h47] = 8'h08;
    for (int i = 4; i < 32; i++) mem_d[8'h40 + 2 * i + 1] = 8'hFF;
    // Small memory: 0xA5A50F0F at 0xFE (wrapping) and its complement at 0x02;
    // two copies of 0xDEADBEEF at 0x10.
    mem_s[8'hFE] = 8'hA5; mem_s[8'hFF] = 8'hA5; mem_s[8'h00] = 8'h0F; mem_s[8'h01] = 8'h0F;
    mem_s[8'h02] = 8'h5A; mem_s[8'h03] = 8'h5A; mem_s[8'h04] = 8'hF0; mem_s[8'h05] = 8'hF0;
    mem_s[8'h10] = 8'hDE; mem_s[8'h11] = 8'hAD; mem_s[8'h12] = 8'hBE; mem_s[8'h13] = 8'hEF;
    mem_s[8'h14] = 8'hDE; mem_s[8'h15] = 8'hAD; mem_s[8'h16] = 8'hBE; mem_s[8'h17] = 8'hEF;

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    check("rst:busy", d_busy, 0);
    check("rst:done", d_done, 0);
    check("rst:rd_en", d_rd_en, 0);
    check("rst:addr", d_addr, 0);
    check_results("rst", 16, 0, 0, 0, 0, 0);
    check("rst_s:min_dist", s_min, 32);
    check("rst_s:done", s_done, 0);
    @(negedge clk);
    reset = 1'b0;

    run(0, 8'h80, 64, 561, 0, 16, "zeros", 0, 0, 1, 0, 0, 0);
    run(0, 8'h00, 64, 561, 0, 16, "op5",   0, 0, 1, 16, 0, 5);
    run(0, 8'h40, 64, 561, 1, 16, "mixed", 0, 4, 5, 7, 0, 4);

    // Reset in the middle of PAIR aborts at once; a fresh run then completes.
    sel = 0;
    @(negedge clk);
    base_addr = 8'h40;
    d_start = 1'b1;
    @(posedge clk); #1;
    d_start = 1'b0;
    repeat (199) @(posedge clk);
    #1;
    check("abort:busy_before", d_busy, 1);
    #2 reset = 1'b1;
    #1;
    check("abort:busy", d_busy, 0);
    check("abort:done", d_done, 0);
    check("abort:rd_en", d_rd_en, 0);
    check_results("abort", 16, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    run(0, 8'h00, 64, 561, 0, 16, "after_abort", 0, 0, 1, 16, 0, 5);

    // N=2: single pair; complement gives W (not below the initial min), identical gives 0.
    run(1, 8'hFE, 8, 10, 0, 32, "compl", 32, 0, 0, 32, 0, 1);
    run(1, 8'h10, 8, 10, 0, 32, "same",  0, 0, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
